// File: rtl/stack_arbiter.sv
// Two-requester round-robin front end for a single stack: grant, one-cycle command strobe, one-cycle ack.
// Define STACK_ARB_ERR_EN to add err0/err1 and suppress commands that would overflow or underflow the stack.
module stack_arbiter #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic             req1,
  input  logic [1:0]       op0,
  input  logic [1:0]       op1,
  input  logic [WIDTH-1:0] din0,
  input  logic [WIDTH-1:0] din1,
  output logic             ack0,
  output logic             ack1,
  output logic [WIDTH-1:0] dout0,
  output logic [WIDTH-1:0] dout1,
  output logic             s_push,
  output logic             s_pop,
  output logic             s_tos,
  output logic [WIDTH-1:0] s_data_in,
  input  logic [WIDTH-1:0] s_data_out,
  input  logic             s_full,
  input  logic             s_empty
`ifdef STACK_ARB_ERR_EN
  ,
  output logic             err0,
  output logic             err1
`endif
);

  localparam logic [1:0] OP_PUSH = 2'b00;
  localparam logic [1:0] OP_POP  = 2'b01;
  localparam logic [1:0] OP_TOS  = 2'b10;

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t           state;
  logic             gnt;
  logic             last;
  logic             sel;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_din;
  logic             fault;
  logic             err_p0;
  logic             err_p1;

  // A tie goes to the requester that was not served last; a lone request wins outright.
  always_comb begin
    sel     = (req0 && req1) ? ~last : ~req0;
    sel_op  = sel ? op1 : op0;
    sel_din = sel ? din1 : din0;
  end

`ifdef STACK_ARB_ERR_EN
  function automatic logic op_fault(input logic [1:0] op, input logic full, input logic empty);
    return ((op == OP_PUSH) && full) || (((op == OP_POP) || (op == OP_TOS)) && empty);
  endfunction

  assign fault = op_fault(sel_op, s_full, s_empty);
  assign err0  = ack0 & err_p1;
  assign err1  = ack1 & err_p1;
`else
  logic unused_flags;
  assign unused_flags = s_full ^ s_empty;
  assign fault        = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      last      <= 1'b1;
      s_push    <= 1'b0;
      s_pop     <= 1'b0;
      s_tos     <= 1'b0;
      s_data_in <= '0;
      ack0      <= 1'b0;
      ack1      <= 1'b0;
      err_p0    <= 1'b0;
      err_p1    <= 1'b0;
    end else begin
      case (state)
        // grant edge: latch requester, data and the command to strobe next cycle
        IDLE: begin
          if (req0 || req1) begin
            gnt       <= sel;
            s_data_in <= sel_din;
            s_push    <= (sel_op == OP_PUSH) && !fault;
            s_pop     <= (sel_op == OP_POP)  && !fault;
            s_tos     <= (sel_op == OP_TOS)  && !fault;
            err_p0    <= fault;
            state     <= ISSUE;
          end
        end
        // strobe cycle ends; the stack's registered read data is valid in RESP
        ISSUE: begin
          s_push <= 1'b0;
          s_pop  <= 1'b0;
          s_tos  <= 1'b0;
          ack0   <= ~gnt;
          ack1   <= gnt;
          err_p1 <= err_p0;
          state  <= RESP;
        end
        // ack cycle ends; served requester loses the next tie
        RESP: begin
          ack0   <= 1'b0;
          ack1   <= 1'b0;
          err_p1 <= 1'b0;
          last   <= gnt;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign dout0 = (ack0 && !err_p1) ? s_data_out : '0;
  assign dout1 = (ack1 && !err_p1) ? s_data_out : '0;

endmodule

// File: doc/stack_arbiter.md
STACK_ARBITER -- requirements
Module: stack_arbiter

Interface
REQ-001 SHALL have parameter WIDTH, default 5, the stack data width.
REQ-002 SHALL have port clk  input  1  clock, rising-edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports req0/req1  input  1  operation request from requester 0/1.
REQ-005 SHALL have ports op0/op1  input  2  operation code: 00 push, 01 pop, 10 tos, 11 no-op.
REQ-006 SHALL have ports din0/din1  input  WIDTH  push data.
REQ-007 SHALL have ports ack0/ack1  output  1  one-cycle completion pulse.
REQ-008 SHALL have ports dout0/dout1  output  WIDTH  result data; valid only while the matching ack is high, 0 otherwise.
REQ-009 SHALL have ports s_push/s_pop/s_tos  output  1  one-cycle stack command strobes.
REQ-010 SHALL have port s_data_in  output  WIDTH  push data to stack.
REQ-011 SHALL have port s_data_out  input  WIDTH  stack read data, registered in the stack.
REQ-012 SHALL have ports s_full/s_empty  input  1  stack status flags.

Function
REQ-013 SHALL implement FSM IDLE -> ISSUE -> RESP -> IDLE; IDLE holds while req0=req1=0.
REQ-014 In IDLE with any req high, SHALL grant one requester at the clock edge, register its op and din, and enter ISSUE.
REQ-015 Arbitration SHALL be round-robin: on simultaneous req, grant the requester not granted last; a single req is granted immediately.
REQ-016 In ISSUE SHALL assert exactly one strobe matching the latched op for exactly one cycle; s_data_in = latched din; no-op asserts no strobe.
REQ-017 In RESP SHALL assert ack of the granted requester only, with dout = s_data_out.
REQ-018 Latency SHALL be: req sampled at edge k, strobe during cycle k+1, ack during cycle k+2; one operation per 3 cycles.
REQ-019 Last-grant pointer SHALL update on leaving RESP.
REQ-020 Requesters hold req, op and din stable until ack; a req still high in the cycle after ack is a new request.
REQ-021 s_push, s_pop and s_tos SHALL never be asserted simultaneously, and SHALL be 0 outside ISSUE.
REQ-022 Changes to req, op or din after the grant edge SHALL not affect the operation in flight.

Reset
REQ-023 rst SHALL immediately force state IDLE, all strobes, acks and douts to 0, s_data_in to 0, and last-grant to requester 1 (requester 0 wins the first tie).
REQ-024 rst asserted during ISSUE or RESP SHALL abort the operation with no ack; the stack is not reset by this block.

Configuration
REQ-025 With macro STACK_ARB_ERR_EN defined, SHALL add outputs err0/err1 (1 bit) and check at the ISSUE edge: push with s_full=1, or pop/tos with s_empty=1, suppresses the strobe and returns ack with err=1, dout=0.
REQ-026 Without STACK_ARB_ERR_EN, err ports SHALL be absent and strobes SHALL be issued regardless of s_full/s_empty.

Verification
REQ-027 Reset, then req0 with op0=00 and din0=5'h0A -> s_push high exactly one cycle at k+1, s_data_in=0A, ack0 at k+2.
REQ-028 Stack holding 0A, then req1 with op1=01 -> s_pop one cycle, ack1 with dout1=0A, ack0 stays 0.
REQ-029 req0 and req1 both held with push ops (din 01 and 02) -> grants alternate 0,1,0,1; after two pushes each, tos returns 02.
REQ-030 Empty stack, pop from req0: without STACK_ARB_ERR_EN -> s_pop strobed and ack0 returned; with it defined -> no strobe, ack0 with err0=1, dout0=0.
REQ-031 rst pulsed during ISSUE of a push -> strobe drops immediately, no ack; the next req0 is served normally with latency 2.
REQ-032 op0=11 -> no strobe issued, ack0 at k+2.
